// File: rtl/clk_mux_cfg_pkg.sv
// Shared types and helpers for the global clock-mux CRAM programming sequencer.
package clk_mux_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SETUP,
        WL,
        HOLD,
        DONE
    } state_t;

    localparam int CRAM_ROWS = 2;
    localparam int BANK_BITS = 4;
    localparam int CFG_W     = 8;
    localparam int ROW_W     = $clog2(CRAM_ROWS);
    localparam int BL_W      = 2 * (BANK_BITS / CRAM_ROWS);

    // Bitline pattern for one CRAM row: low pair feeds the left bank, high pair the right.
    function automatic logic [BL_W-1:0] bl_map(input logic [ROW_W-1:0] row,
                                               input logic [CFG_W-1:0] data);
        logic [BL_W-1:0] bl;
        bl[1:0] = data[2*int'(row) +: 2];
        bl[3:2] = data[BANK_BITS + 2*int'(row) +: 2];
        return bl;
    endfunction

endpackage

// File: rtl/clk_mux_cfg_timer.sv
// Loadable down-counter with a zero flag; it parks at zero instead of wrapping.
module clk_mux_cfg_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/clk_mux_cfg_seq.sv
// Programming sequencer for the 4-net global clock-mux CRAM banks: clear both banks,
// then write them row by row through bitlines, pass gates and wordline pulses.
import clk_mux_cfg_pkg::*;

module clk_mux_cfg_seq #(
    parameter int RST_CYC   = 4,
    parameter int SETUP_CYC = 2,
    parameter int WL_CYC    = 4,
    parameter int HOLD_CYC  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    input  logic [CFG_W-1:0] cfg_data,
    output logic             cfg_ready,
    input  logic             pwr_dn,
    output logic             busy,
    output logic             done,
    output logic             prog,
    output logic [BL_W-1:0]  bl_out,
    output logic             bl_oe,
    output logic [1:0]       wl_l,
    output logic [1:0]       wl_r,
    output logic [1:0]       pgate_l,
    output logic [1:0]       pgate_r,
    output logic [1:0]       reset_l,
    output logic [1:0]       reset_r,
    output logic [1:0]       vdd_cntl_l,
    output logic [1:0]       vdd_cntl_r
);

    localparam int MAX_RS  = (RST_CYC > SETUP_CYC) ? RST_CYC : SETUP_CYC;
    localparam int MAX_WH  = (WL_CYC > HOLD_CYC) ? WL_CYC : HOLD_CYC;
    localparam int MAX_CYC = (MAX_RS > MAX_WH) ? MAX_RS : MAX_WH;
    localparam int TMR_W   = $clog2(MAX_CYC) + 1;

    state_t             state_reg, state_next;
    logic [ROW_W-1:0]   row_reg, row_next;
    logic [CFG_W-1:0]   data_reg;
    logic               timer_load;
    logic [TMR_W-1:0]   timer_val;
    logic               timer_zero;
    logic               accept;
    logic               in_row_next;
    logic [CRAM_ROWS-1:0] pgate_next, wl_next;

    logic               busy_reg, done_reg, prog_reg, bl_oe_reg;
    logic [BL_W-1:0]    bl_out_reg;
    logic [1:0]         wl_reg, pgate_reg, clr_reg, vdd_reg;

    assign cfg_ready = (state_reg == IDLE) && !pwr_dn;
    assign accept    = cfg_valid && cfg_ready;

    clk_mux_cfg_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    // Next state and timer reload; each state entry reloads the timer with its length minus one.
    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        timer_load = 1'b0;
        timer_val  = '0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = CLR;
                    row_next   = '0;
                    timer_load = 1'b1;
                    timer_val  = TMR_W'(RST_CYC - 1);
                end
            end
            CLR: begin
                if (timer_zero) begin
                    state_next = SETUP;
                    row_next   = '0;
                    timer_load = 1'b1;
                    timer_val  = TMR_W'(SETUP_CYC - 1);
                end
            end
            SETUP: begin
                if (timer_zero) begin
                    state_next = WL;
                    timer_load = 1'b1;
                    timer_val  = TMR_W'(WL_CYC - 1);
                end
            end
            WL: begin
                if (timer_zero) begin
                    state_next = HOLD;
                    timer_load = 1'b1;
                    timer_val  = TMR_W'(HOLD_CYC - 1);
                end
            end
            HOLD: begin
                if (timer_zero) begin
                    timer_load = 1'b1;
                    if (row_reg == ROW_W'(CRAM_ROWS - 1)) begin
                        state_next = DONE;
                        timer_val  = '0;
                    end else begin
                        state_next = SETUP;
                        row_next   = row_reg + 1'b1;
                        timer_val  = TMR_W'(SETUP_CYC - 1);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                timer_load = 1'b1;
                timer_val  = '0;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_row_next = (state_next == SETUP) || (state_next == WL) || (state_next == HOLD);

    genvar gi;
    generate
        for (gi = 0; gi < CRAM_ROWS; gi++) begin : g_row
            assign pgate_next[gi] = in_row_next && (row_next == ROW_W'(gi));
            assign wl_next[gi]    = (state_next == WL) && (row_next == ROW_W'(gi));
        end
    endgenerate

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            row_reg    <= '0;
            data_reg   <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            prog_reg   <= 1'b0;
            bl_oe_reg  <= 1'b0;
            bl_out_reg <= '0;
            wl_reg     <= '0;
            pgate_reg  <= '0;
            clr_reg    <= '0;
            vdd_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            row_reg    <= row_next;
            if (accept) begin
                data_reg <= cfg_data;
            end
            busy_reg   <= (state_next != IDLE);
            prog_reg   <= (state_next != IDLE);
            done_reg   <= (state_next == DONE);
            bl_oe_reg  <= in_row_next;
            bl_out_reg <= in_row_next ? bl_map(row_next, data_reg) : '0;
            wl_reg     <= wl_next;
            pgate_reg  <= pgate_next;
            clr_reg    <= (state_next == CLR) ? 2'b11 : 2'b00;
            vdd_reg    <= ((state_reg == IDLE) && pwr_dn) ? 2'b11 : 2'b00;
        end
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign prog       = prog_reg;
    assign bl_oe      = bl_oe_reg;
    assign bl_out     = bl_out_reg;
    assign wl_l       = wl_reg;
    assign wl_r       = wl_reg;
    assign pgate_l    = pgate_reg;
    assign pgate_r    = pgate_reg;
    assign reset_l    = clr_reg;
    assign reset_r    = clr_reg;
    assign vdd_cntl_l = vdd_reg;
    assign vdd_cntl_r = vdd_reg;

endmodule

// File: tb/tb_clk_mux_cfg_seq.sv
// Directed bench for clk_mux_cfg_seq: default-timing instance plus an all-ones-timing instance.
module tb_clk_mux_cfg_seq;

    logic       clk;
    logic       reset;
    logic       cfg_valid, cfg_valid1;
    logic [7:0] cfg_data, cfg_data1;
    logic       pwr_dn, pwr_dn1;

    logic       cfg_ready, busy, done, prog, bl_oe;
    logic [3:0] bl_out;
    logic [1:0] wl_l, wl_r, pgate_l, pgate_r, reset_l, reset_r, vdd_cntl_l, vdd_cntl_r;

    logic       cfg_ready1, busy1, done1, prog1, bl_oe1;
    logic [3:0] bl_out1;
    logic [1:0] wl_l1, wl_r1, pgate_l1, pgate_r1, reset_l1, reset_r1, vdd_cntl_l1, vdd_cntl_r1;

    logic [24:0] outs0, outs1;
    int tests = 0;
    int fails = 0;

    localparam logic [24:0] IDLE_VEC = 25'h1000000;
    localparam logic [24:0] PD_VEC   = 25'h000000F;

    typedef struct {
        logic [7:0] data;
        logic [3:0] bl0;
        logic [3:0] bl1;
    } vec_t;
    vec_t vecs[6];

    clk_mux_cfg_seq dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready), .pwr_dn(pwr_dn), .busy(busy), .done(done), .prog(prog),
        .bl_out(bl_out), .bl_oe(bl_oe), .wl_l(wl_l), .wl_r(wl_r),
        .pgate_l(pgate_l), .pgate_r(pgate_r), .reset_l(reset_l), .reset_r(reset_r),
        .vdd_cntl_l(vdd_cntl_l), .vdd_cntl_r(vdd_cntl_r)
    );

    clk_mux_cfg_seq #(
        .RST_CYC(1), .SETUP_CYC(1), .WL_CYC(1), .HOLD_CYC(1)
    ) dut1 (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid1), .cfg_data(cfg_data1),
        .cfg_ready(cfg_ready1), .pwr_dn(pwr_dn1), .busy(busy1), .done(done1), .prog(prog1),
        .bl_out(bl_out1), .bl_oe(bl_oe1), .wl_l(wl_l1), .wl_r(wl_r1),
        .pgate_l(pgate_l1), .pgate_r(pgate_r1), .reset_l(reset_l1), .reset_r(reset_r1),
        .vdd_cntl_l(vdd_cntl_l1), .vdd_cntl_r(vdd_cntl_r1)
    );

    assign outs0 = {cfg_ready, busy, done, prog, bl_out, bl_oe, wl_l, wl_r,
                    pgate_l, pgate_r, reset_l, reset_r, vdd_cntl_l, vdd_cntl_r};
    assign outs1 = {cfg_ready1, busy1, done1, prog1, bl_out1, bl_oe1, wl_l1, wl_r1,
                    pgate_l1, pgate_r1, reset_l1, reset_r1, vdd_cntl_l1, vdd_cntl_r1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected output vector n edges after the cycle in which the word was offered (n=1 is the accept edge).
    function automatic logic [24:0] exp_outs(input int n, input logic [3:0] b0, input logic [3:0] b1,
                                             input int r, input int s, input int w, input int h,
                                             input bit rdy);
        logic       cr, bz, dn, pg, oe;
        logic [3:0] bl;
        logic [1:0] wl, pgt, rs;
        int t, u, v, seg, row;
        cr = 0; bz = 0; dn = 0; pg = 0; oe = 0; bl = '0; wl = '0; pgt = '0; rs = '0;
        t = n - 1;
        seg = s + w + h;
        if (t < r) begin
            bz = 1; pg = 1; rs = 2'b11;
        end else begin
            u = t - r;
            if (u < 2 * seg) begin
                row = u / seg;
                v = u % seg;
                bz = 1; pg = 1; oe = 1;
                bl = (row != 0) ? b1 : b0;
                pgt = (row == 0) ? 2'b01 : 2'b10;
                if (v >= s && v < s + w) wl = pgt;
            end else if (u == 2 * seg) begin
                bz = 1; pg = 1; dn = 1;
            end else begin
                cr = rdy;
            end
        end
        return {cr, bz, dn, pg, bl, oe, wl, wl, pgt, pgt, rs, rs, 4'b0000};
    endfunction

    task automatic run_txn(input bit sel, input logic [7:0] d, input logic [3:0] b0, input logic [3:0] b1,
                           input int r, input int s, input int w, input int h,
                           input bit keep_valid, input logic [7:0] d2, input int pd_at);
        int total, err0;
        logic [24:0] act;
        logic ok;
        total = r + 2 * (s + w + h) + 1;
        err0 = fails;
        @(negedge clk);
        if (sel) begin cfg_valid1 = 1'b1; cfg_data1 = d; end
        else begin cfg_valid = 1'b1; cfg_data = d; end
        for (int n = 1; n <= total + 1; n++) begin
            @(posedge clk);
            #1;
            act = sel ? outs1 : outs0;
            check($sformatf("%s_d%h_n%0d", sel ? "p1" : "def", d, n), act,
                  exp_outs(n, b0, b1, r, s, w, h, pd_at == 0));
            ok = $onehot0(act[15:14]) && $onehot0(act[13:12]) && !((|act[15:12]) && (|act[7:4]));
            check($sformatf("wl_excl_%s_d%h_n%0d", sel ? "p1" : "def", d, n), ok, 1);
            if (n == 1) begin
                if (keep_valid) cfg_data = d2;
                else if (sel) cfg_valid1 = 1'b0;
                else cfg_valid = 1'b0;
            end
            if (pd_at != 0 && n == pd_at) pwr_dn = 1'b1;
        end
        $display("[TB] txn %s data=%h done_at=%0d errors=%0d", sel ? "p1" : "def", d, total, fails - err0);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 4'b1001, 4'b1001};
        vecs[1] = '{8'h3C, 4'b1100, 4'b0011};
        vecs[2] = '{8'h00, 4'b0000, 4'b0000};
        vecs[3] = '{8'hFF, 4'b1111, 4'b1111};
        vecs[4] = '{8'h1E, 4'b0110, 4'b0011};
        vecs[5] = '{8'hC3, 4'b0011, 4'b1100};

        reset = 1'b1;
        cfg_valid = 0; cfg_data = 0; pwr_dn = 0;
        cfg_valid1 = 0; cfg_data1 = 0; pwr_dn1 = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", outs0, IDLE_VEC);
        check("reset_state_p1", outs1, IDLE_VEC);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset", outs0, IDLE_VEC);
        $display("[TB] txn reset released");

        for (int i = 0; i < 6; i++)
            run_txn(0, vecs[i].data, vecs[i].bl0, vecs[i].bl1, 4, 2, 4, 2, 0, 8'h00, 0);

        // cfg_valid held through busy with new data: taken only once cfg_ready returns.
        run_txn(0, 8'hA5, 4'b1001, 4'b1001, 4, 2, 4, 2, 1, 8'h3C, 0);
        run_txn(0, 8'h3C, 4'b1100, 4'b0011, 4, 2, 4, 2, 0, 8'h00, 0);

        // Reset asserted during the row-1 wordline pulse.
        @(negedge clk);
        cfg_valid = 1'b1; cfg_data = 8'h3C;
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) cfg_valid = 1'b0;
        end
        check("pre_rst_wl_l", wl_l, 2'b10);
        #2;
        reset = 1'b1;
        #1;
        check("rst_wl_l", wl_l, 2'b00);
        check("rst_wl_r", wl_r, 2'b00);
        check("rst_prog", prog, 1'b0);
        check("rst_bl_oe", bl_oe, 1'b0);
        check("rst_ready", cfg_ready, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("after_mid_reset", outs0, IDLE_VEC);
        $display("[TB] txn mid-op reset");
        run_txn(0, 8'hC3, 4'b0011, 4'b1100, 4, 2, 4, 2, 0, 8'h00, 0);

        // Power-down in IDLE, then pwr_dn raised while busy.
        @(negedge clk);
        pwr_dn = 1'b1; cfg_valid = 1'b1; cfg_data = 8'h55;
        @(posedge clk);
        #1;
        check("pd_idle", outs0, PD_VEC);
        @(posedge clk);
        #1;
        check("pd_no_accept", outs0, PD_VEC);
        @(negedge clk);
        pwr_dn = 1'b0; cfg_valid = 1'b0;
        @(posedge clk);
        #1;
        check("pd_release", outs0, IDLE_VEC);
        $display("[TB] txn power-down idle");
        run_txn(0, 8'h1E, 4'b0110, 4'b0011, 4, 2, 4, 2, 0, 8'h00, 3);
        @(posedge clk);
        #1;
        check("pd_after_done", outs0, PD_VEC);
        @(negedge clk);
        pwr_dn = 1'b0;
        @(posedge clk);
        #1;
        check("pd_clear", outs0, IDLE_VEC);
        $display("[TB] txn power-down after busy");

        // Minimum timing: done eight cycles after the word is offered.
        run_txn(1, 8'h1E, 4'b0110, 4'b0011, 1, 1, 1, 1, 0, 8'h00, 0);
        run_txn(1, 8'hC3, 4'b0011, 4'b1100, 1, 1, 1, 1, 0, 8'h00, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
